// File: rtl/cfexec_pkg.sv
// rtl/cfexec_pkg.sv - shared function codes, magnet bit indices and sequencer states for cfexec
package cfexec_pkg;

  localparam logic [4:0] FD_NONE       = 5'd0;
  localparam logic [4:0] FD_SPACE      = 5'd1;
  localparam logic [4:0] FD_CR         = 5'd2;
  localparam logic [4:0] FD_NL         = 5'd3;
  localparam logic [4:0] FD_SHIFT_UP   = 5'd4;
  localparam logic [4:0] FD_SHIFT_DOWN = 5'd5;
  localparam logic [4:0] FD_TAB        = 5'd6;
  localparam logic [4:0] FD_BACKSPACE  = 5'd7;
  localparam logic [4:0] FD_INDEX      = 5'd8;

  localparam int MAG_SPACE     = 0;
  localparam int MAG_CR        = 1;
  localparam int MAG_INDEX     = 2;
  localparam int MAG_SHIFT_UP  = 3;
  localparam int MAG_SHIFT_DN  = 4;
  localparam int MAG_TAB       = 5;
  localparam int MAG_BACKSPACE = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_DWELL,
    ST_SETTLE
  } state_t;

  // Shift codes only fire when they would actually change the current case.
  function automatic logic [6:0] fd_mag(input logic [4:0] fd, input logic upper);
    logic [6:0] m;
    m = '0;
    case (fd)
      FD_SPACE:      m[MAG_SPACE] = 1'b1;
      FD_CR:         m[MAG_CR] = 1'b1;
      FD_NL:         begin m[MAG_CR] = 1'b1; m[MAG_INDEX] = 1'b1; end
      FD_SHIFT_UP:   m[MAG_SHIFT_UP] = ~upper;
      FD_SHIFT_DOWN: m[MAG_SHIFT_DN] = upper;
      FD_TAB:        m[MAG_TAB] = 1'b1;
      FD_BACKSPACE:  m[MAG_BACKSPACE] = 1'b1;
      FD_INDEX:      m[MAG_INDEX] = 1'b1;
      default:       m = '0;
    endcase
    return m;
  endfunction

  function automatic logic fd_legal(input logic [4:0] fd);
    return (fd != FD_NONE) && (fd <= FD_INDEX);
  endfunction

endpackage

// File: rtl/cf_timer.sv
// rtl/cf_timer.sv - loadable 8-bit down-counter; done while the count sits at zero
module cf_timer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_done
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_done = (r_cnt == 8'd0);

endmodule

// File: rtl/cfexec.sv
// rtl/cfexec.sv - console typewriter function-execution sequencer driving Selectric magnets
// Optional carrier-home contact sensing during carrier return: CFEXEC_CR_HOME_EN
module cfexec
  import cfexec_pkg::*;
#(
  parameter int MAG_CYCLES    = 3,
  parameter int CR_CYCLES     = 12,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_function,
  input  logic [4:0] i_fd,
  input  logic       i_cr_home,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_case_latch,
  output logic       o_cr_latch,
  output logic [6:0] o_mag,
  output logic       o_fault
);

  // Timer is loaded with duration-1 so done coincides with the last clock of a state.
  localparam logic [7:0] L_MAG_M1 = 8'(MAG_CYCLES - 1);
  localparam logic [7:0] L_CR_M1  = 8'(CR_CYCLES - 1);
  localparam logic [7:0] L_SET_M1 = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_fd;
  logic [6:0] r_mag;
  logic       r_case;
  logic       r_cr;
  logic       r_fault;

  logic       w_done;
  logic       w_load;
  logic [7:0] w_load_val;
  logic       w_accept;
  logic       w_pulse_end;
  logic       w_dwell_end;
  logic       w_home_fault;
  logic [6:0] w_mask;
  logic       w_is_cr;

  assign w_mask  = fd_mag(i_fd, r_case);
  assign w_is_cr = (r_fd == FD_CR) || (r_fd == FD_NL);

`ifdef CFEXEC_CR_HOME_EN
  logic [1:0] r_lap;
  logic       w_lap_inc;
`else
  logic       w_unused;
  assign w_unused = i_cr_home;
`endif

  cf_timer u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_accept     = 1'b0;
    w_pulse_end  = 1'b0;
    w_dwell_end  = 1'b0;
    w_home_fault = 1'b0;
`ifdef CFEXEC_CR_HOME_EN
    w_lap_inc    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_function) begin
          w_accept = 1'b1;
          w_load   = 1'b1;
          if (w_mask != 7'd0) begin
            w_next     = ST_PULSE;
            w_load_val = L_MAG_M1;
          end else begin
            w_next     = ST_SETTLE;
            w_load_val = L_SET_M1;
          end
        end
      end
      ST_PULSE: begin
        if (w_done) begin
          w_pulse_end = 1'b1;
          w_load      = 1'b1;
          if (w_is_cr) begin
            w_next     = ST_DWELL;
            w_load_val = L_CR_M1;
          end else begin
            w_next     = ST_SETTLE;
            w_load_val = L_SET_M1;
          end
        end
      end
      ST_DWELL: begin
`ifdef CFEXEC_CR_HOME_EN
        // Timeout of four CR dwells is built from reloads of the shared 8-bit timer.
        if (i_cr_home) begin
          w_dwell_end = 1'b1;
        end else if (w_done) begin
          if (r_lap == 2'd3) begin
            w_dwell_end  = 1'b1;
            w_home_fault = 1'b1;
          end else begin
            w_load     = 1'b1;
            w_load_val = L_CR_M1;
            w_lap_inc  = 1'b1;
          end
        end
`else
        if (w_done) begin
          w_dwell_end = 1'b1;
        end
`endif
        if (w_dwell_end) begin
          w_next     = ST_SETTLE;
          w_load     = 1'b1;
          w_load_val = L_SET_M1;
        end
      end
      ST_SETTLE: begin
        if (w_done) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

`ifdef CFEXEC_CR_HOME_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lap <= '0;
    end else if (w_pulse_end) begin
      r_lap <= '0;
    end else if (w_lap_inc) begin
      r_lap <= r_lap + 2'd1;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fd    <= FD_NONE;
      r_mag   <= '0;
      r_case  <= 1'b0;
      r_cr    <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fd  <= i_fd;
        r_mag <= w_mask;
        r_cr  <= (i_fd == FD_CR) || (i_fd == FD_NL);
        if (!fd_legal(i_fd)) begin
          r_fault <= 1'b1;
        end
      end
      // A shift only reaches PULSE when it changes case, so toggling here is exact.
      if (w_pulse_end) begin
        r_mag <= '0;
        if ((r_fd == FD_SHIFT_UP) || (r_fd == FD_SHIFT_DOWN)) begin
          r_case <= ~r_case;
        end
      end
      if (w_dwell_end) begin
        r_cr <= 1'b0;
      end
      if (w_home_fault) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign o_ready      = (r_state == ST_IDLE);
  assign o_busy       = ~o_ready;
  assign o_case_latch = r_case;
  assign o_cr_latch   = r_cr;
  assign o_mag        = r_mag;
  assign o_fault      = r_fault;

endmodule
